// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor d = a - b, one bit per clock, LSB first.
// Operands arrive and results leave over valid/ready handshakes.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             br;
    logic             msb_a;
    logic             msb_b;

    logic ai;
    logic bi;
    logic di;
    logic br_next;
    logic last_bit;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SHIFT;
            SHIFT:   if (last_bit)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Single full-subtractor cell working on the current LSBs.
    always_comb begin
        ai       = opa[0];
        bi       = opb[0];
        di       = ai ^ bi ^ br;
        br_next  = (~ai & bi) | (~(ai ^ bi) & br);
        last_bit = (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            in_ready  <= (state_next == IDLE);
            out_valid <= (state_next == DONE);
        end
    end

    // The minuend register doubles as the result register: each difference
    // bit enters at the MSB as the consumed operand bit leaves at the LSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt      <= '0;
            br       <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            msb_a    <= 1'b0;
            msb_b    <= 1'b0;
            d        <= '0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= b;
                        msb_a <= a[WIDTH-1];
                        msb_b <= b[WIDTH-1];
                        br    <= 1'b0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    opa <= {di, opa[WIDTH-1:1]};
                    opb <= {1'b0, opb[WIDTH-1:1]};
                    br  <= br_next;
                    if (last_bit) begin
                        d        <= {di, opa[WIDTH-1:1]};
                        borrow   <= br_next;
                        overflow <= (msb_a != msb_b) && (di != msb_a);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8): latency,
// arithmetic flags, backpressure, operand changes and mid-operation reset.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] d;
    logic       borrow;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .borrow    (borrow),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Accepts one operand pair, optionally scrambles a/b during SHIFT, and
    // waits (bounded) for out_valid, checking the 8-cycle latency.
    task automatic applyStimulus(input string tag, input logic [7:0] va, input logic [7:0] vb, input bit scramble);
        int cycles;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
        if (scramble) begin
            a = 8'hFF;
            b = 8'hFF;
        end
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
        checkOutput({tag, " latency"}, 32'(cycles), 32'd8);
    endtask

    task automatic checkResult(input string tag, input logic [7:0] exp_d, input logic exp_b, input logic exp_o);
        checkOutput({tag, " d"}, 32'(d), 32'(exp_d));
        checkOutput({tag, " borrow"}, 32'(borrow), 32'(exp_b));
        checkOutput({tag, " overflow"}, 32'(overflow), 32'(exp_o));
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        checkOutput({tag, " in_ready after consume"}, 32'(in_ready), 32'd1);
        checkOutput({tag, " out_valid after consume"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = 8'h00;
        b         = 8'h00;
        tick();
        tick();
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkResult("reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        applyStimulus("05-03", 8'h05, 8'h03, 1'b0);
        checkResult("05-03", 8'h02, 1'b0, 1'b0);
        consume("05-03");

        applyStimulus("03-05", 8'h03, 8'h05, 1'b0);
        checkResult("03-05", 8'hFE, 1'b1, 1'b0);
        consume("03-05");

        applyStimulus("80-01", 8'h80, 8'h01, 1'b0);
        checkResult("80-01", 8'h7F, 1'b0, 1'b1);
        consume("80-01");

        applyStimulus("7F-FF", 8'h7F, 8'hFF, 1'b0);
        checkResult("7F-FF", 8'h80, 1'b1, 1'b1);
        consume("7F-FF");

        // Backpressure: result held while a stray in_valid is ignored.
        out_ready = 1'b0;
        applyStimulus("bp", 8'h10, 8'h01, 1'b0);
        checkResult("bp", 8'h0F, 1'b0, 1'b0);
        in_valid = 1'b1;
        a        = 8'h44;
        b        = 8'h22;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("bp hold d", 32'(d), 32'h0F);
            checkOutput("bp hold out_valid", 32'(out_valid), 32'd1);
            checkOutput("bp hold in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        consume("bp");
        checkOutput("bp d kept after consume", 32'(d), 32'h0F);

        applyStimulus("AA-55 scrambled", 8'hAA, 8'h55, 1'b1);
        checkResult("AA-55 scrambled", 8'h55, 1'b0, 1'b1);
        consume("AA-55 scrambled");

        // Reset asserted at the 4th bit edge aborts the operation.
        a        = 8'h33;
        b        = 8'h11;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midreset d", 32'(d), 32'h00);
        checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset overflow", 32'(overflow), 32'd0);

        applyStimulus("09-09", 8'h09, 8'h09, 1'b0);
        checkResult("09-09", 8'h00, 1'b0, 1'b0);
        consume("09-09");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
